// File: rtl/gate_truth_table_sweeper.sv
// gate_truth_table_sweeper: drives a/b through 00..11 and checks the six gate outputs against a golden set.
// Optional GTTS_CAPTURE_EN adds fail_vec/fail_res holding the first mismatch of a sweep.
module gate_truth_table_sweeper #(
    parameter int MODE          = 0,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [5:0] res,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count
`ifdef GTTS_CAPTURE_EN
    ,
    output logic [1:0] fail_vec,
    output logic [5:0] fail_res
`endif
);
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic       a_q, b_q, busy_q, done_q, pass_q;
    logic [3:0] err_mask_q, err_mask_d;
    logic [2:0] err_count_q, err_count_d;
    logic [5:0] golden;
    logic       mism;
`ifdef GTTS_CAPTURE_EN
    logic [1:0] fail_vec_q;
    logic [5:0] fail_res_q;
    assign fail_vec = fail_vec_q;
    assign fail_res = fail_res_q;
`endif

    always_comb begin
        golden      = {~(a_q ^ b_q), a_q ^ b_q, (MODE != 0) ? ~(a_q & b_q) : ~(a_q | b_q),
                       a_q | b_q, a_q & b_q, ~a_q};
        mism        = res != golden;
        err_mask_d  = err_mask_q | (mism ? 4'b0001 << vec_q : 4'b0000);
        err_count_d = err_count_q + {2'b00, mism};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_mask_q  <= '0;
            err_count_q <= '0;
`ifdef GTTS_CAPTURE_EN
            fail_vec_q  <= '0;
            fail_res_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q     <= DRIVE;
                    vec_q       <= '0;
                    {a_q, b_q}  <= 2'b00;
                    busy_q      <= 1'b1;
                    done_q      <= 1'b0;
                    pass_q      <= 1'b0;
                    err_mask_q  <= '0;
                    err_count_q <= '0;
`ifdef GTTS_CAPTURE_EN
                    fail_vec_q  <= '0;
                    fail_res_q  <= '0;
`endif
                end
                DRIVE: begin
                    state_q <= SETTLE;
                    cnt_q   <= '0;
                end
                SETTLE: if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_q <= SAMPLE;
                        else cnt_q <= cnt_q + 4'd1;
                SAMPLE: begin
                    err_mask_q  <= err_mask_d;
                    err_count_q <= err_count_d;
`ifdef GTTS_CAPTURE_EN
                    // an empty count means no earlier vector of this sweep failed
                    if (mism && err_count_q == 3'd0) begin
                        fail_vec_q <= vec_q;
                        fail_res_q <= res;
                    end
`endif
                    if (vec_q == 2'd3) begin
                        state_q    <= DONE;
                        {a_q, b_q} <= 2'b00;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= err_mask_d == 4'd0;
                    end else begin
                        state_q    <= DRIVE;
                        vec_q      <= vec_q + 2'd1;
                        {a_q, b_q} <= vec_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_gate_truth_table_sweeper.sv
// tb_gate_truth_table_sweeper: three sweeper instances (MODE/SETTLE variants) fed by a gate model with injectable faults.
module tb_gate_truth_table_sweeper;
    localparam int N = 3;
    localparam int MODES   [N] = '{0, 1, 0};
    localparam int SETTLES [N] = '{2, 1, 15};

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pass;
        logic [1:0] fv;
        logic [5:0] fr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start [N];
    logic       a [N], b [N], busy [N], done [N], pass [N];
    logic [5:0] res [N];
    logic [3:0] err_mask [N];
    logic [2:0] err_count [N];
`ifdef GTTS_CAPTURE_EN
    logic [1:0] fail_vec [N];
    logic [5:0] fail_res [N];
`endif
    int   fm [N];
    int   checks = 0;
    int   errors = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : gen_dut
        gate_truth_table_sweeper #(.MODE(MODES[g]), .SETTLE_CYCLES(SETTLES[g])) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .a(a[g]), .b(b[g]), .res(res[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]),
            .err_mask(err_mask[g]), .err_count(err_count[g])
`ifdef GTTS_CAPTURE_EN
            , .fail_vec(fail_vec[g]), .fail_res(fail_res[g])
`endif
        );
    end

    function automatic logic [5:0] gold(input int m, input logic x, input logic y);
        logic [5:0] r;
        r[0] = !x;
        r[1] = x && y;
        r[2] = x || y;
        r[3] = (m != 0) ? !(x && y) : !(x || y);
        r[4] = x != y;
        r[5] = x == y;
        return r;
    endfunction

    // fault 0 ideal gates, 1 XNOR wrong for a=1,b=0 only, 2 outputs stuck low
    function automatic logic [5:0] model(input int m, input int f, input logic x, input logic y);
        logic [5:0] r;
        r = gold(m, x, y);
        if (f == 1 && x && !y) r[5] = !r[5];
        if (f == 2) r = '0;
        return r;
    endfunction

    always_comb
        for (int i = 0; i < N; i++) res[i] = model(MODES[i], fm[i], a[i], b[i]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int i);
        chk(tag, {busy[i], done[i], pass[i], err_mask[i], err_count[i], a[i], b[i]}, 0);
`ifdef GTTS_CAPTURE_EN
        chk({tag, "_cap"}, {fail_vec[i], fail_res[i]}, 0);
`endif
    endtask

    // called at a negedge; start is sampled at the following edge E
    task automatic sweep(input int i, input int f, input bit ign);
        int         n;
        exp_t       e, o;
        logic [5:0] r;
        n     = 4 * (SETTLES[i] + 2);
        e     = '0;
        fm[i] = f;
        for (int v = 0; v < 4; v++) begin
            r = model(MODES[i], f, v[1], v[0]);
            if (r != gold(MODES[i], v[1], v[0])) begin
                if (e.cnt == 0) begin
                    e.fv = 2'(v);
                    e.fr = r;
                end
                e.mask[v] = 1'b1;
                e.cnt++;
            end
        end
        e.pass = e.mask == 0;
        sb.push_back(e);
        start[i] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("i%0d_run_k%0d", i, k), {busy[i], done[i], a[i], b[i]},
                {2'b10, 2'(k / (SETTLES[i] + 2))});
            start[i] = ign && (k == 3 || k == 9);
            @(negedge clk);
        end
        start[i] = 1'b0;
        chk($sformatf("i%0d_done_time", i), done[i], 1);
        o = sb.pop_front();
        chk($sformatf("i%0d_mask", i), err_mask[i], o.mask);
        chk($sformatf("i%0d_count", i), err_count[i], o.cnt);
        chk($sformatf("i%0d_pass", i), pass[i], o.pass);
        chk($sformatf("i%0d_done_ab", i), {busy[i], a[i], b[i]}, 0);
`ifdef GTTS_CAPTURE_EN
        chk($sformatf("i%0d_fail_vec", i), fail_vec[i], o.fv);
        chk($sformatf("i%0d_fail_res", i), fail_res[i], o.fr);
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            start[i] = 1'b0;
            fm[i]    = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) chk_idle($sformatf("i%0d_reset", i), i);
        rst_n = 1'b1;
        @(negedge clk);
        sweep(0, 0, 0);
        sweep(1, 1, 0);
        sweep(2, 2, 0);
        sweep(0, 0, 1);
        sweep(0, 2, 0);
        sweep(0, 0, 0);
        sweep(1, 0, 0);
        // abort vector 2 in SETTLE with errors already recorded
        fm[0]    = 2;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort", {busy[0], a[0], b[0], err_mask[0]}, {3'b110, 4'b0011});
        #1 rst_n = 1'b0;
        #1 chk_idle("abort_async", 0);
        @(negedge clk);
        chk_idle("abort_held", 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("abort_idle", 0);
        sweep(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
